// File: rtl/passcode_enroll_pkg.sv
// Shared types and constants for the passcode enrollment path.
// The helpers map digit slot 0..3 onto code bits [15:12]..[3:0].
package passcode_enroll_pkg;

    typedef logic [3:0] digit_t;

    typedef enum logic [2:0] {
        sIdle    = 3'd0,
        sNew     = 3'd1,
        sConfirm = 3'd2,
        sCommit  = 3'd3,
        sFail    = 3'd4
    } enroll_state_t;

    localparam logic [15:0] DEFAULT_CODE = 16'h1224;
    localparam digit_t      DIGIT_BLANK  = 4'h0;

    function automatic digit_t get_digit(input logic [15:0] code, input logic [1:0] idx);
        return code[{~idx, 2'b00} +: 4];
    endfunction

    function automatic logic [15:0] set_digit(input logic [15:0] code, input logic [1:0] idx,
                                              input digit_t d);
        logic [15:0] res;
        res = code;
        res[{~idx, 2'b00} +: 4] = d;
        return res;
    endfunction

endpackage

// File: rtl/passcode_enroll_btn_one_shot.sv
// Press detector for an active-low button: one-cycle pulse, registered, one cycle after
// the first low sample. Holding the button produces no repeats; there is no backpressure.
module btn_one_shot (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    logic prev_q, prev_d;
    logic press_q, press_d;

    always_comb begin
        prev_d  = ~btn_n;
        press_d = ~btn_n & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/passcode_enroll.sv
// Two-pass passcode enrollment: new digits, then confirm; commit updates code_word the cycle
// after the done pulse. One press consumed per cycle; enroll_en low aborts any entry.
module passcode_enroll
    import passcode_enroll_pkg::*;
#(
    parameter logic [15:0] DEFAULT_CODE   = 16'h1224,
    parameter int          TIMEOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn0,
    input  logic [3:0]  SW,
    input  logic        enroll_en,
    output logic [15:0] code_word,
    output logic        enroll_busy,
    output logic        enroll_done,
    output logic        enroll_fail,
    output logic [2:0]  enroll_state,
    output logic [3:0]  led
);

    localparam int           TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    enroll_state_t state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   scratch_q, scratch_d;
    logic [15:0]   code_q, code_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          press;

    btn_one_shot u_one_shot (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_n (btn0),
        .press (press)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        scratch_d = scratch_q;
        code_d    = code_q;
        tmo_d     = '0;
        case (state_q)
            sIdle: begin
                if (enroll_en && press) begin
                    if (SW != DIGIT_BLANK) begin
                        scratch_d = set_digit(scratch_q, 2'd0, SW);
                        idx_d     = 2'd1;
                        state_d   = sNew;
                    end else begin
                        state_d = sFail;
                    end
                end
            end
            sNew, sConfirm: begin
                tmo_d = press ? '0 : tmo_q + TW'(1);
                // Abort outranks a press arriving in the same cycle.
                if (!enroll_en) begin
                    state_d   = sIdle;
                    idx_d     = 2'd0;
                    scratch_d = '0;
                end else if (press) begin
                    if (state_q == sNew) begin
                        if (SW == DIGIT_BLANK) begin
                            state_d = sFail;
                            idx_d   = 2'd0;
                        end else begin
                            scratch_d = set_digit(scratch_q, idx_q, SW);
                            if (idx_q == 2'd3) begin
                                idx_d   = 2'd0;
                                state_d = sConfirm;
                            end else begin
                                idx_d = idx_q + 2'd1;
                            end
                        end
                    end else if (SW != get_digit(scratch_q, idx_q)) begin
                        state_d = sFail;
                        idx_d   = 2'd0;
                    end else if (idx_q == 2'd3) begin
                        state_d = sCommit;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = sFail;
                    idx_d   = 2'd0;
                end
            end
            sCommit: begin
                code_d    = scratch_q;
                scratch_d = '0;
                idx_d     = 2'd0;
                state_d   = sIdle;
            end
            sFail: begin
                scratch_d = '0;
                idx_d     = 2'd0;
                state_d   = sIdle;
            end
            default: begin
                scratch_d = '0;
                idx_d     = 2'd0;
                state_d   = sIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= sIdle;
            idx_q     <= 2'd0;
            scratch_q <= '0;
            code_q    <= DEFAULT_CODE;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            scratch_q <= scratch_d;
            code_q    <= code_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        led = 4'b0000;
        if (state_q == sNew || state_q == sConfirm) begin
            led = ~(4'hF >> idx_q);
        end
    end

    assign code_word    = code_q;
    assign enroll_busy  = (state_q != sIdle);
    assign enroll_done  = (state_q == sCommit);
    assign enroll_fail  = (state_q == sFail);
    assign enroll_state = state_q;

endmodule

// File: doc/passcode_enroll.md
Name: passcode_enroll

Overview:
- Writer side of the passcode path: lets the user program a new 4-digit code (4-bit switch digits) and holds it for the passcode checker.
- Enrollment is a two-pass entry: four new digits, then the same four again to confirm. A matching confirm commits the code; a mismatch, zero digit or timeout leaves the stored code unchanged.
- Sits beside the checker. The system FSM gates it with enroll_en, which is high only while disarmed/idle.

Parameters:
- DEFAULT_CODE, 16'h1224, code loaded at reset; digit0 in [15:12], digit3 in [3:0].
- TIMEOUT_CYCLES, 50_000_000, clk cycles allowed between accepted presses before an enrollment fails.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- btn0  input  1  raw enter button, active-low (pressed = 0).
- SW  input  4  digit value.
- enroll_en  input  1  system permits enrollment (level).
- code_word  output  16  committed passcode, consumed by the checker.
- enroll_busy  output  1  high in any state other than sIdle.
- enroll_done  output  1  one-cycle pulse on commit.
- enroll_fail  output  1  one-cycle pulse on rejection.
- enroll_state  output  3  current state encoding.
- led  output  4  thermometer of digits taken in the current pass (bit3 = first digit).

Behaviour:
- Reset (async, rst_n=0):
  - Registers: code_word=DEFAULT_CODE; state=sIdle; idx=0; scratch=0; timeout count=0; one-shot previous=0.
  - Outputs: enroll_busy, enroll_done and enroll_fail are 0; led=0.
- Press event:
  - press = ~btn0 & ~prev, registered.
  - It is high exactly one cycle, one cycle after btn0 first samples low. Holding the button gives no repeats.
- States (3-bit): sIdle=0, sNew=1, sConfirm=2, sCommit=3, sFail=4; 5-7 go to sIdle.
- sIdle:
  - If enroll_en && press && SW!=0: scratch[digit0]=SW, idx=1, go to sNew.
  - If enroll_en && press && SW==0: go to sFail.
  - Otherwise stay.
- sNew, on press:
  - SW==0: go to sFail.
  - Otherwise store SW in scratch digit idx.
  - If idx==3: idx=0, go to sConfirm. Else idx++.
- sConfirm, on press:
  - SW != scratch digit idx: go to sFail immediately.
  - Match with idx==3: go to sCommit.
  - Match otherwise: idx++.
- sCommit:
  - Lasts one cycle with enroll_done=1.
  - code_word<=scratch at the exiting edge, so the new code is visible the cycle after the done pulse.
  - Then go to sIdle.
- sFail: lasts one cycle with enroll_fail=1, then sIdle. scratch is cleared; code_word is unchanged.
- Timeout:
  - Counter clears on every press and in sIdle/sCommit/sFail, and increments in sNew/sConfirm.
  - When it reaches TIMEOUT_CYCLES-1 with no press in that cycle: go to sFail.
  - A press in the same cycle wins.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- enroll_en deasserted in sNew/sConfirm: abort to sIdle next cycle. No done or fail pulse, code_word unchanged, scratch cleared. Abort takes priority over a simultaneous press.
- enroll_en low in sCommit: the commit still completes.
- led:
  - sNew: the top idx bits set (idx=2 gives 1100).
  - sConfirm: the same pattern from the confirm idx.
  - All other states: 0.
- Reset mid-operation: immediate return to the reset values; any partial entry is lost.

Decomposition:
- Shared package:
  - enroll_state_t enum (sIdle..sFail).
  - digit_t (logic[3:0]).
  - DEFAULT_CODE and DIGIT_BLANK=4'h0 constants.
  - The existing fsm_state_t stays where it is.
- Sub-module btn_one_shot (clk, rst_n, btn_n, press). The checker's one-shot should later reuse it.

Test Plan:
- Reset, then idle 10 cycles -> code_word=16'h1224, enroll_busy=0, no pulses.
- enroll_en=1; presses with SW=3,5,7,9, then 3,5,7,9 -> after the 8th press, state 2→3; enroll_done one cycle; next cycle code_word=16'h3579, enroll_busy=0.
- Enter 3,5,7,9, then confirm 3,6 -> enroll_fail pulse on the cycle after the 6th press event; code_word still 16'h1224; led=0.
- Run with TIMEOUT_CYCLES=16: press SW=4, then no press for 16 cycles -> enroll_fail pulse at count 15; a press landing exactly on cycle 15 instead advances idx with no fail.
- Enter 2 digits, drop enroll_en -> state=0 next cycle, no pulses, led=0. A fresh full enrollment then still works.
- Hold btn0 low 20 cycles with SW=8 -> exactly one digit taken (led=1000). A press with SW=0 -> enroll_fail. Assert rst_n=0 mid-confirm -> all outputs return to their reset values immediately.
